sine_dds_gen: RTL and testbench



---
 rtl/sine_dds_gen.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_sine_dds_gen.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sine_dds_gen.sv
`default_nettype none
// ============================================================================
// Module      : sine_dds_gen
// Description : Direct-digital-synthesis waveform generator. A phase
//               accumulator advanced once per prescaled sample tick drives a
//               three-stage pipeline that produces sine (quarter-wave LUT),
//               triangle, square or saw samples. Samples are scaled by an
//               8-bit amplitude, and a first-order sigma-delta modulator
//               turns the sample stream into a 1-bit PDM stream.
// Ports       : clk          - clock
//               rst_n        - synchronous active-low reset
//               wr_en        - register write strobe
//               wr_addr[2:0] - register address (0..2 FTW, 3 AMP, 4 CTRL)
//               wr_data[7:0] - register write data
//               sample_out   - offset-binary sample, AMP_W bits
//               sample_valid - one-cycle pulse when sample_out updates
//               pdm_out      - sigma-delta bitstream of sample_out
//               sync_out     - one-cycle pulse in a tick that wraps the phase
// Revision    : 1.0 - initial release
// ============================================================================
module sine_dds_gen #(
    parameter int PHASE_W    = 24,
    parameter int LUT_ADDR_W = 6,
    parameter int AMP_W      = 8,
    parameter int DIV        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [2:0]       wr_addr,
    input  logic [7:0]       wr_data,
    output logic [AMP_W-1:0] sample_out,
    output logic             sample_valid,
    output logic             pdm_out,
    output logic             sync_out
);

    localparam int c_lut_n   = 1 << LUT_ADDR_W;
    localparam int c_presc_w = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int c_m       = (1 << (AMP_W - 1)) - 1;
    localparam int c_ww      = AMP_W + 2;    // waveform working width
    localparam int c_pw      = AMP_W + 11;   // scaler product width

    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(DIV - 1);
    localparam logic [AMP_W-1:0]     c_mid        = AMP_W'(1 << (AMP_W - 1));
    localparam logic signed [c_ww-1:0] c_pos_m = c_ww'(c_m);
    localparam logic signed [c_ww-1:0] c_neg_m = -c_pos_m;
    localparam logic signed [c_ww-1:0] c_mid_s = c_ww'(1 << (AMP_W - 1));

    localparam logic [2:0] c_addr_ftw0 = 3'd0;
    localparam logic [2:0] c_addr_ftw1 = 3'd1;
    localparam logic [2:0] c_addr_ftw2 = 3'd2;
    localparam logic [2:0] c_addr_amp  = 3'd3;
    localparam logic [2:0] c_addr_ctrl = 3'd4;

    localparam logic [1:0] c_mode_sine   = 2'b00;
    localparam logic [1:0] c_mode_tri    = 2'b01;
    localparam logic [1:0] c_mode_square = 2'b10;
    localparam logic [1:0] c_mode_saw    = 2'b11;

    // Quarter-wave entry i = round(M * sin(pi/2 * (i + 0.5) / N)), evaluated
    // at elaboration with a Taylor series so no math library is needed.
    function automatic int lut_entry(input int i);
        real x;
        real term;
        real sum;
        x    = 3.14159265358979323846 / 2.0 * (real'(i) + 0.5) / real'(c_lut_n);
        term = x;
        sum  = x;
        for (int k = 1; k < 12; k++) begin
            term = -term * x * x / real'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        return $rtoi(real'(c_m) * sum + 0.5);
    endfunction

    logic [AMP_W-2:0] w_lut [c_lut_n];

    for (genvar gi = 0; gi < c_lut_n; gi++) begin : g_lut
        localparam logic [AMP_W-2:0] c_entry = (AMP_W - 1)'(lut_entry(gi));
        assign w_lut[gi] = c_entry;
    end

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    logic [15:0]        r_shadow;
    logic [PHASE_W-1:0] r_ftw;
    logic [7:0]         r_amp;
    logic               r_enable;
    logic [1:0]         r_mode;
    logic [23:0]        w_ftw_commit;

    assign w_ftw_commit = {wr_data, r_shadow};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shadow <= '0;
            r_ftw    <= '0;
            r_amp    <= 8'hFF;
            r_enable <= 1'b0;
            r_mode   <= c_mode_sine;
        end else if (wr_en) begin
            case (wr_addr)
                c_addr_ftw0: r_shadow[7:0]  <= wr_data;
                c_addr_ftw1: r_shadow[15:8] <= wr_data;
                c_addr_ftw2: r_ftw          <= w_ftw_commit[PHASE_W-1:0];
                c_addr_amp:  r_amp          <= wr_data;
                c_addr_ctrl: begin
                    r_enable <= wr_data[0];
                    r_mode   <= wr_data[2:1];
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Prescaler and phase accumulator
    // ------------------------------------------------------------------
    logic                 w_ctrl_wr;
    logic                 w_phase_clear;
    logic                 w_en_next;
    logic                 w_run;
    logic                 w_tick;
    logic                 w_carry;
    logic [PHASE_W-1:0]   w_phase_sum;
    logic                 w_s1_load;
    logic [c_presc_w-1:0] r_presc;
    logic [PHASE_W-1:0]   r_phase;

    assign w_ctrl_wr     = wr_en && (wr_addr == c_addr_ctrl);
    assign w_phase_clear = w_ctrl_wr && wr_data[3];
    // A CTRL write that drops enable takes effect on this very edge, so the
    // output returns to mid-scale one cycle after the write.
    assign w_en_next     = w_ctrl_wr ? wr_data[0] : r_enable;
    assign w_run         = r_enable && w_en_next;
    assign w_tick        = w_run && (r_presc == c_presc_last);
    assign {w_carry, w_phase_sum} = {1'b0, r_phase} + {1'b0, r_ftw};
    // A cleared phase does not advance, so it cannot wrap or issue a sample.
    assign w_s1_load     = w_tick && !w_phase_clear;
    assign sync_out      = w_s1_load && w_carry;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_phase <= '0;
        end else begin
            if (!w_run || w_tick) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + c_presc_w'(1);
            end
            if (w_phase_clear) begin
                r_phase <= '0;
            end else if (w_tick) begin
                r_phase <= w_phase_sum;
            end
        end
    end

    // ------------------------------------------------------------------
    // S1: phase decode
    // ------------------------------------------------------------------
    logic                  r_s1_valid;
    logic [1:0]            r_s1_quad;
    logic [LUT_ADDR_W-1:0] r_s1_idx;
    logic [AMP_W-1:0]      r_s1_u;
    logic [1:0]            r_s1_mode;
    logic [7:0]            r_s1_amp;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_quad  <= '0;
            r_s1_idx   <= '0;
            r_s1_u     <= '0;
            r_s1_mode  <= c_mode_sine;
            r_s1_amp   <= '0;
        end else begin
            r_s1_valid <= w_s1_load;
            if (w_s1_load) begin
                r_s1_quad <= r_phase[PHASE_W-1 -: 2];
                r_s1_idx  <= r_phase[PHASE_W-3 -: LUT_ADDR_W];
                r_s1_u    <= r_phase[PHASE_W-1 -: AMP_W];
                r_s1_mode <= r_mode;
                r_s1_amp  <= r_amp;
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: waveform shaping, signed result in [-M, +M]
    // ------------------------------------------------------------------
    logic [LUT_ADDR_W-1:0]   w_lut_addr;
    logic signed [c_ww-1:0]  w_lut_s;
    logic signed [c_ww-1:0]  w_u_s;
    logic signed [c_ww-1:0]  w_wave;
    logic                    r_s2_valid;
    logic signed [c_ww-1:0]  r_s2_wave;
    logic [7:0]              r_s2_amp;

    always_comb begin
        // Odd quadrants read the table backwards: N-1-idx == ~idx.
        w_lut_addr = r_s1_quad[0] ? ~r_s1_idx : r_s1_idx;
        w_lut_s    = $signed({3'b000, w_lut[w_lut_addr]});
        w_u_s      = $signed({2'b00, r_s1_u});
        w_wave     = '0;
        case (r_s1_mode)
            c_mode_sine:   w_wave = r_s1_quad[1] ? -w_lut_s : w_lut_s;
            c_mode_tri:    w_wave = !r_s1_u[AMP_W-1] ? (w_u_s <<< 1) - c_pos_m
                                                     : c_pos_m - ((w_u_s - c_mid_s) <<< 1);
            c_mode_square: w_wave = r_s1_quad[1] ? c_neg_m : c_pos_m;
            c_mode_saw:    w_wave = (r_s1_u == '0) ? c_neg_m : w_u_s - c_mid_s;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_wave  <= '0;
            r_s2_amp   <= '0;
        end else begin
            r_s2_valid <= w_en_next && r_s1_valid;
            if (r_s1_valid) begin
                r_s2_wave <= w_wave;
                r_s2_amp  <= r_s1_amp;
            end
        end
    end

    // ------------------------------------------------------------------
    // S3: amplitude scaling and offset to unsigned
    // ------------------------------------------------------------------
    logic signed [c_pw-1:0] w_prod;
    logic [AMP_W-1:0]       w_scaled;
    logic [AMP_W-1:0]       w_sample_next;

    // Bits [AMP_W+7:8] of the full product are (s*AMP) >>> 8, floor-rounded.
    assign w_prod        = c_pw'(r_s2_wave) * $signed({{(c_pw - 8){1'b0}}, r_s2_amp});
    assign w_scaled      = w_prod[AMP_W+7:8];
    assign w_sample_next = c_mid + w_scaled;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample_out   <= c_mid;
            sample_valid <= 1'b0;
        end else if (!w_en_next) begin
            sample_out   <= c_mid;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= r_s2_valid;
            if (r_s2_valid) begin
                sample_out <= w_sample_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // First-order sigma-delta: carry out of the accumulator is the PDM bit
    // ------------------------------------------------------------------
    logic [AMP_W-1:0] r_sigma;
    logic [AMP_W:0]   w_pdm_sum;

    assign w_pdm_sum = {1'b0, r_sigma} + {1'b0, sample_out};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sigma <= '0;
            pdm_out <= 1'b0;
        end else begin
            r_sigma <= w_pdm_sum[AMP_W-1:0];
            pdm_out <= w_pdm_sum[AMP_W];
        end
    end

    // FTW bits above PHASE_W and the discarded product bits are intentionally dropped.
    logic w_unused;
    assign w_unused = &{1'b0, w_ftw_commit, w_prod[7:0], w_prod[c_pw-1:AMP_W+8], 1'b0};

endmodule
`default_nettype wire

// File: tb/tb_sine_dds_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_sine_dds_gen
// Description : Self-checking bench for sine_dds_gen (DIV=1). A behavioural
//               model tracks phase, registers and the sample stream using
//               plain arithmetic and $sin; every clock all outputs are
//               compared. Directed steps are followed by random writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sine_dds_gen;

    localparam int PHASE_W    = 24;
    localparam int LUT_ADDR_W = 6;
    localparam int AMP_W      = 8;
    localparam int DIV        = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [7:0] wr_data = 8'd0;
    logic [AMP_W-1:0] sample_out;
    logic       sample_valid;
    logic       pdm_out;
    logic       sync_out;

    int checks = 0;
    int errors = 0;

    // Model state
    int unsigned m_phase, m_ftw, m_shadow;
    int  m_amp, m_mode, m_out, m_acc, m_x1, m_x2;
    bit  m_en, m_v1, m_v2, m_vout, m_pdm;

    sine_dds_gen #(
        .PHASE_W    (PHASE_W),
        .LUT_ADDR_W (LUT_ADDR_W),
        .AMP_W      (AMP_W),
        .DIV        (DIV)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .pdm_out      (pdm_out),
        .sync_out     (sync_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected sample for a given pre-increment phase, mode and amplitude.
    function automatic int ref_sample(input int unsigned ph, input int mode, input int amp);
        int q;
        int u;
        int idx;
        int k;
        int s;
        int mag;
        real pi;
        pi  = 3.14159265358979;
        q   = int'(ph >> 22);
        u   = int'(ph >> 16);
        idx = u % 64;
        case (mode)
            0: begin
                k   = (q % 2 == 1) ? 63 - idx : idx;
                mag = $rtoi(127.0 * $sin(pi / 2.0 * (real'(k) + 0.5) / 64.0) + 0.5);
                s   = (q >= 2) ? -mag : mag;
            end
            1: s = (u < 128) ? 2 * u - 127 : 127 - 2 * (u - 128);
            2: s = (ph >= 32'h800000) ? -127 : 127;
            default: s = (u - 128 < -127) ? -127 : u - 128;
        endcase
        return 128 + ((s * amp) >>> 8);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_ftw = 0; m_shadow = 0; m_amp = 255; m_mode = 0; m_en = 0;
        m_v1 = 0; m_v2 = 0; m_vout = 0; m_out = 128; m_acc = 0; m_pdm = 0;
        m_x1 = 0; m_x2 = 0;
    endtask

    task automatic do_reset(input int n);
        wr_en = 1'b0;
        rst_n = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        check("rst_sample_out", sample_out, 128);
        check("rst_sample_valid", sample_valid, 0);
        check("rst_pdm_out", pdm_out, 0);
        check("rst_sync_out", sync_out, 0);
    endtask

    // One clock: drive a (possible) write, check sync_out mid-cycle, then
    // advance the model over the edge and check the registered outputs.
    task automatic cyc(input bit we, input int addr, input int data);
        bit ctrl_wr, clr, en_next, tick, carry;
        int unsigned sum;
        int pre_out;
        wr_en   = we;
        wr_addr = addr[2:0];
        wr_data = data[7:0];
        ctrl_wr = we && (addr == 4);
        clr     = ctrl_wr && data[3];
        en_next = ctrl_wr ? data[0] : m_en;
        tick    = m_en && en_next;
        sum     = m_phase + m_ftw;
        carry   = (sum >= 32'h1000000);
        @(negedge clk);
        check("sync_out", sync_out, {31'd0, tick && carry && !clr});
        @(posedge clk);
        #1;
        pre_out = m_out;
        if (!en_next) begin
            m_v1 = 0; m_v2 = 0; m_vout = 0; m_out = 128;
        end else begin
            m_vout = m_v2;
            if (m_v2) m_out = m_x2;
            m_v2 = m_v1;
            m_x2 = m_x1;
            m_v1 = tick && !clr;
            if (m_v1) m_x1 = ref_sample(m_phase, m_mode, m_amp);
        end
        m_pdm = (m_acc + pre_out) >= 256;
        m_acc = (m_acc + pre_out) % 256;
        if (clr) m_phase = 0;
        else if (tick) m_phase = sum & 32'hFFFFFF;
        if (we) begin
            case (addr)
                0: m_shadow = (m_shadow & 32'hFF00) | data;
                1: m_shadow = (m_shadow & 32'h00FF) | (data << 8);
                2: m_ftw    = (data << 16) | m_shadow;
                3: m_amp    = data;
                4: begin
                    m_en   = data[0];
                    m_mode = (data >> 1) & 3;
                end
                default: ;
            endcase
        end
        wr_en = 1'b0;
        check("sample_valid", sample_valid, {31'd0, m_vout});
        check("sample_out", sample_out, m_out);
        check("pdm_out", pdm_out, {31'd0, m_pdm});
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0);
    endtask

    task automatic wr_ftw(input int unsigned f);
        cyc(1, 0, int'(f & 255));
        cyc(1, 1, int'((f >> 8) & 255));
        cyc(1, 2, int'((f >> 16) & 255));
    endtask

    initial begin
        int lit[4];
        int prev;
        int ones;
        int r;
        int a;
        int d;
        lit = '{129, 254, 126, 1};
        model_reset();

        // Reset and idle while disabled
        do_reset(2);
        idle(4);

        // Sine, FTW = quarter turn
        wr_ftw(32'h400000);
        cyc(1, 3, 8'hFF);
        cyc(1, 4, 8'h01);
        idle(2);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0);
            check("sine_literal", sample_out, lit[i % 4]);
            check("sine_valid_every_clk", sample_valid, 1);
        end

        // Square: FTW=0 from cleared phase, then AMP 0x80 / 0x00
        wr_ftw(0);
        cyc(1, 4, 8'h0D);
        cyc(1, 3, 8'h80);
        idle(4);
        check("square_amp80", sample_out, 191);
        cyc(1, 3, 8'h00);
        idle(4);
        check("square_amp0", sample_out, 128);
        cyc(1, 3, 8'h80);
        wr_ftw(32'h800000);
        idle(4);
        prev = int'(sample_out);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 0);
            check("square_alternate", sample_out, (prev == 191) ? 64 : 191);
            prev = int'(sample_out);
        end

        // Shadow writes do not disturb the active FTW; commit in a tick cycle
        cyc(1, 4, 8'h01);
        cyc(1, 3, 8'hFF);
        wr_ftw(32'h400000);
        idle(6);
        cyc(1, 0, 8'h00);
        cyc(1, 1, 8'h00);
        idle(4);
        cyc(1, 2, 8'h20);
        idle(6);

        // Saw and triangle with a fine FTW
        cyc(1, 4, 8'h07);
        wr_ftw(32'h0A3D71);
        idle(10);
        cyc(1, 4, 8'h03);
        idle(10);

        // Phase clear: the clearing tick issues no sample
        cyc(1, 4, 8'h01);
        wr_ftw(32'h200000);
        idle(5);
        cyc(1, 4, 8'h09);
        idle(2);
        check("clear_no_sample", sample_valid, 0);
        cyc(0, 0, 0);
        check("after_clear_phase0", sample_out, 129);
        idle(3);

        // Disable: mid-scale next cycle, no further valids
        cyc(1, 4, 8'h00);
        check("disable_mid", sample_out, 128);
        check("disable_no_valid", sample_valid, 0);
        idle(4);

        // Reset mid-run
        cyc(1, 4, 8'h01);
        idle(5);
        do_reset(1);
        idle(4);

        // PDM density for constant 191
        cyc(1, 4, 8'h05);
        wr_ftw(0);
        cyc(1, 4, 8'h0D);
        cyc(1, 3, 8'h80);
        idle(8);
        ones = 0;
        for (int i = 0; i < 256; i++) begin
            cyc(0, 0, 0);
            ones += int'(pdm_out);
        end
        check("pdm_ones_191pm1", {31'd0, (ones >= 190) && (ones <= 192)}, 1);

        // Random register traffic
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 65) begin
                cyc(0, 0, 0);
            end else begin
                a = int'($urandom_range(0, 7));
                d = int'($urandom_range(0, 255));
                if (a == 4) begin
                    if ($urandom_range(0, 9) < 8) d = d | 1;
                    if ($urandom_range(0, 9) < 7) d = d & 8'hF7;
                end
                cyc(1, a, d);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
